pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage pipeline that the opcode decoder feeds. Tracks in-flight
//  destination regs in shadow EX/MEM/WB slots, and drives PC/IFID write enables,
//  IFID flush, the IDEX bubble and EX operand forwarding selects.
//  Owns halt draining (RUN->DRAIN->HALTED) and a load-use stall counter.
// PARAMETERS
//  RF_AW         5   register-file address width
//  DRAIN_CYCLES  3   cycles from halt issue to HALT (EX, MEM, WB of halt instr)
//  CNT_W         16  width of STALL_CNT
// PORTS
//  CLK           in   1      clock, rising edge
//  RST           in   1      asynchronous reset, active-high
//  ID_VALID      in   1      ID stage holds a real instruction
//  ID_RS1/ID_RS2 in   RF_AW  source regs of ID instr
//  ID_USE_RS1/2  in   1      ID instr reads rs1 / rs2
//  ID_RD         in   RF_AW  dest reg of ID instr
//  ID_RF_WE      in   1      ID instr writes RF (decoder RF_WE)
//  ID_IS_LOAD    in   1      ID instr is a load (decoder isLoad)
//  HALT_REQ      in   1      ID instr is the halt instruction
//  EX_REDIRECT   in   1      EX resolved taken branch / jump
//  PC_WE         out  1      PC update enable
//  IFID_WE       out  1      IF/ID latch enable
//  IFID_FLUSH    out  1      clear IF/ID to NOP
//  IDEX_BUBBLE   out  1      insert NOP into ID/EX instead of ID instr
//  FWD_A/FWD_B   out  2      EX operand src: 00 RF, 01 MEM result, 10 WB data
//  HALT          out  1      pipeline drained and stopped (sticky)
//  STALL_CNT     out  CNT_W  load-use stall cycles, saturating
// BEHAVIOUR
//  Reset (RST=1, async): slots invalid, state RUN, STALL_CNT=0, HALT=0; while RST
//   high PC_WE=0, IFID_WE=0, IFID_FLUSH=0, IDEX_BUBBLE=1, FWD_A=FWD_B=00.
//  Slots: EX{v,rd,we,ld,rs1,rs2,u1,u2}, MEM{v,rd,we,ld}, WB{v,rd,we}. Every cycle
//   WB<=MEM, MEM<=EX; EX<=ID fields with v=ID_VALID, or v=0 if IDEX_BUBBLE.
//  issue = ID_VALID & !IDEX_BUBBLE. Writes to rd=0 never count as hazards.
//  load_use = EX.v&EX.ld&EX.we&EX.rd!=0&ID_VALID&((ID_USE_RS1&ID_RS1==EX.rd)
//   |(ID_USE_RS2&ID_RS2==EX.rd)).
//  RUN priority (combinational from slots + inputs, same cycle):
//   1 EX_REDIRECT: PC_WE=1, IFID_WE=1, IFID_FLUSH=1, IDEX_BUBBLE=1; load_use and
//     HALT_REQ ignored (wrong path).
//   2 load_use: PC_WE=0, IFID_WE=0, IDEX_BUBBLE=1; STALL_CNT+1 (sat at all-ones).
//     Exactly one stall cycle per load-use pair.
//   3 else PC_WE=IFID_WE=1, FLUSH=0, BUBBLE=0. If HALT_REQ&ID_VALID: halt issues,
//     next state DRAIN, drain counter<=DRAIN_CYCLES-1.
//  DRAIN: PC_WE=IFID_WE=0, IFID_FLUSH=1, IDEX_BUBBLE=1, EX_REDIRECT ignored;
//   counter decrements; at 0 next state HALTED.
//  HALTED: HALT=1, PC_WE=IFID_WE=0, IDEX_BUBBLE=1; exits only via RST.
//  Forwarding (per EX operand, only if EX.v & use bit): MEM.v&MEM.we&MEM.rd!=0&
//   rd match -> 01 (priority); else WB same -> 10; else 00. MEM.ld match cannot
//   occur (stall); assertion flags it.
//  Reset mid-DRAIN: immediate return to RUN, HALT=0, slots cleared.
// TESTING
//  lw x5 in EX, add x6,x5,x7 in ID -> 1 cycle PC_WE=0,IDEX_BUBBLE=1; next cycle
//   add in EX with FWD_A=10; STALL_CNT=1.
//  lw x0 in EX, ID reads x0 -> no stall; FWD_A=00.
//  add x3 in MEM and x3 in WB, EX reads x3 as rs2 -> FWD_B=01 (MEM wins).
//  EX_REDIRECT=1 with load_use true -> IFID_FLUSH=1, IDEX_BUBBLE=1, PC_WE=1,
//   STALL_CNT unchanged.
//  HALT_REQ issued at cycle t -> DRAIN t+1..t+3, HALT=1 from t+4, PC_WE=0 after.
//  RST pulse mid-DRAIN, STALL_CNT=0xFFFF sat test -> state RUN, HALT=0, CNT=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundles the decoder-side request signals and the hazard controller's
//   pipeline-control responses into one interface.
//   master : decode/ID stage side (drives ID_* / HALT_REQ / EX_REDIRECT)
//   slave  : hazard controller side (drives PC/IFID/IDEX controls, forwarding
//            selects, HALT and STALL_CNT)
interface pipe_hazard_ctrl_if #(
  parameter int unsigned RF_AW = 5,
  parameter int unsigned CNT_W = 16
);
  logic             ID_VALID;
  logic [RF_AW-1:0] ID_RS1;
  logic [RF_AW-1:0] ID_RS2;
  logic             ID_USE_RS1;
  logic             ID_USE_RS2;
  logic [RF_AW-1:0] ID_RD;
  logic             ID_RF_WE;
  logic             ID_IS_LOAD;
  logic             HALT_REQ;
  logic             EX_REDIRECT;

  logic             PC_WE;
  logic             IFID_WE;
  logic             IFID_FLUSH;
  logic             IDEX_BUBBLE;
  logic [1:0]       FWD_A;
  logic [1:0]       FWD_B;
  logic             HALT;
  logic [CNT_W-1:0] STALL_CNT;

  modport master (
    output ID_VALID, ID_RS1, ID_RS2, ID_USE_RS1, ID_USE_RS2, ID_RD,
           ID_RF_WE, ID_IS_LOAD, HALT_REQ, EX_REDIRECT,
    input  PC_WE, IFID_WE, IFID_FLUSH, IDEX_BUBBLE, FWD_A, FWD_B,
           HALT, STALL_CNT
  );

  modport slave (
    input  ID_VALID, ID_RS1, ID_RS2, ID_USE_RS1, ID_USE_RS2, ID_RD,
           ID_RF_WE, ID_IS_LOAD, HALT_REQ, EX_REDIRECT,
    output PC_WE, IFID_WE, IFID_FLUSH, IDEX_BUBBLE, FWD_A, FWD_B,
           HALT, STALL_CNT
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard/sequencing controller for a 5-stage pipeline. Shadows the
//   destination regs of instructions in EX/MEM/WB, stalls one cycle on a
//   load-use pair, flushes on EX redirect, selects EX operand forwarding and
//   drains the pipeline after a halt instruction (RUN -> DRAIN -> HALTED).
// Ports
//   CLK  : clock, rising edge
//   RST  : asynchronous reset, active-high
//   bus  : slave side of pipe_hazard_ctrl_if
//          in  ID_VALID, ID_RS1/2, ID_USE_RS1/2, ID_RD, ID_RF_WE, ID_IS_LOAD,
//              HALT_REQ, EX_REDIRECT
//          out PC_WE, IFID_WE, IFID_FLUSH, IDEX_BUBBLE, FWD_A/B (00 RF,
//              01 MEM, 10 WB), HALT (sticky), STALL_CNT (saturating)
module pipe_hazard_ctrl #(
  parameter int unsigned RF_AW        = 5,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input logic               CLK,
  input logic               RST,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic             v;
    logic [RF_AW-1:0] rd;
    logic             we;
    logic             ld;
    logic [RF_AW-1:0] rs1;
    logic [RF_AW-1:0] rs2;
    logic             u1;
    logic             u2;
  } ex_slot_t;

  typedef struct packed {
    logic             v;
    logic [RF_AW-1:0] rd;
    logic             we;
    logic             ld;
  } mem_slot_t;

  typedef struct packed {
    logic             v;
    logic [RF_AW-1:0] rd;
    logic             we;
  } wb_slot_t;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ex_slot_t         ex_q, ex_d;
  mem_slot_t        mem_q, mem_d;
  wb_slot_t         wb_q, wb_d;

  logic             load_use;
  logic             pc_we, ifid_we, flush, bubble;
  logic [1:0]       fwd_a, fwd_b;
  logic             mem_ld_hit;

  // MEM result has priority over WB data; rd=0 is never a producer.
  function automatic logic [1:0] fwd_sel(
    input logic             ex_v,
    input logic             use_rs,
    input logic [RF_AW-1:0] rs,
    input mem_slot_t        m,
    input wb_slot_t         w
  );
    fwd_sel = 2'b00;
    if (ex_v && use_rs) begin
      if (m.v && m.we && (m.rd != '0) && (m.rd == rs))
        fwd_sel = 2'b01;
      else if (w.v && w.we && (w.rd != '0) && (w.rd == rs))
        fwd_sel = 2'b10;
    end
  endfunction

  always_comb begin
    load_use = ex_q.v && ex_q.ld && ex_q.we && (ex_q.rd != '0) && bus.ID_VALID &&
               ((bus.ID_USE_RS1 && (bus.ID_RS1 == ex_q.rd)) ||
                (bus.ID_USE_RS2 && (bus.ID_RS2 == ex_q.rd)));
  end

  always_comb begin
    pc_we   = 1'b0;
    ifid_we = 1'b0;
    flush   = 1'b0;
    bubble  = 1'b1;
    state_d = state_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (bus.EX_REDIRECT) begin
          // wrong-path ID instr: load_use and HALT_REQ deliberately ignored
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          flush   = 1'b1;
          bubble  = 1'b1;
        end else if (load_use) begin
          // next cycle EX holds the bubble, so load_use drops after one stall
          if (cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          bubble  = 1'b0;
          if (bus.HALT_REQ && bus.ID_VALID) begin
            state_d = ST_DRAIN;
            drain_d = DW'(DRAIN_CYCLES - 1);
          end
        end
      end
      ST_DRAIN: begin
        flush = 1'b1;
        if (drain_q == '0)
          state_d = ST_HALTED;
        else
          drain_d = drain_q - DW'(1);
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    ex_d     = '0;
    ex_d.v   = bus.ID_VALID && !bubble;
    ex_d.rd  = bus.ID_RD;
    ex_d.we  = bus.ID_RF_WE;
    ex_d.ld  = bus.ID_IS_LOAD;
    ex_d.rs1 = bus.ID_RS1;
    ex_d.rs2 = bus.ID_RS2;
    ex_d.u1  = bus.ID_USE_RS1;
    ex_d.u2  = bus.ID_USE_RS2;
    mem_d.v  = ex_q.v;
    mem_d.rd = ex_q.rd;
    mem_d.we = ex_q.we;
    mem_d.ld = ex_q.ld;
    wb_d.v   = mem_q.v;
    wb_d.rd  = mem_q.rd;
    wb_d.we  = mem_q.we;
  end

  always_comb begin
    fwd_a = fwd_sel(ex_q.v, ex_q.u1, ex_q.rs1, mem_q, wb_q);
    fwd_b = fwd_sel(ex_q.v, ex_q.u2, ex_q.rs2, mem_q, wb_q);
    mem_ld_hit = ex_q.v && mem_q.v && mem_q.ld && mem_q.we && (mem_q.rd != '0) &&
                 ((ex_q.u1 && (ex_q.rs1 == mem_q.rd)) ||
                  (ex_q.u2 && (ex_q.rs2 == mem_q.rd)));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  // Controls are forced to their idle values while reset is held.
  assign bus.PC_WE       = pc_we & ~RST;
  assign bus.IFID_WE     = ifid_we & ~RST;
  assign bus.IFID_FLUSH  = flush & ~RST;
  assign bus.IDEX_BUBBLE = bubble | RST;
  assign bus.FWD_A       = fwd_a;
  assign bus.FWD_B       = fwd_b;
  assign bus.HALT        = (state_q == ST_HALTED);
  assign bus.STALL_CNT   = cnt_q;

  // A load result still in MEM when its consumer is in EX means a missed stall.
  assert property (@(posedge CLK) disable iff (RST) !mem_ld_hit);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pipe_hazard_ctrl_if #(.RF_AW(5), .CNT_W(16)) u_if ();
  pipe_hazard_ctrl_if #(.RF_AW(5), .CNT_W(3))  s_if ();

  pipe_hazard_ctrl #(.RF_AW(5), .DRAIN_CYCLES(3), .CNT_W(16)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (u_if.slave)
  );

  // Narrow-counter copy sharing the same stimulus, used for saturation.
  pipe_hazard_ctrl #(.RF_AW(5), .DRAIN_CYCLES(3), .CNT_W(3)) u_sat (
    .CLK (CLK),
    .RST (RST),
    .bus (s_if.slave)
  );

  assign s_if.ID_VALID    = u_if.ID_VALID;
  assign s_if.ID_RS1      = u_if.ID_RS1;
  assign s_if.ID_RS2      = u_if.ID_RS2;
  assign s_if.ID_USE_RS1  = u_if.ID_USE_RS1;
  assign s_if.ID_USE_RS2  = u_if.ID_USE_RS2;
  assign s_if.ID_RD       = u_if.ID_RD;
  assign s_if.ID_RF_WE    = u_if.ID_RF_WE;
  assign s_if.ID_IS_LOAD  = u_if.ID_IS_LOAD;
  assign s_if.HALT_REQ    = u_if.HALT_REQ;
  assign s_if.EX_REDIRECT = u_if.EX_REDIRECT;

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic pc, input logic ifw,
                         input logic fl, input logic bb);
    chk({tag, ".pc_we"},   32'(u_if.PC_WE),       32'(pc));
    chk({tag, ".ifid_we"}, 32'(u_if.IFID_WE),     32'(ifw));
    chk({tag, ".flush"},   32'(u_if.IFID_FLUSH),  32'(fl));
    chk({tag, ".bubble"},  32'(u_if.IDEX_BUBBLE), 32'(bb));
  endtask

  task automatic id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic u1, input logic u2, input logic [4:0] rd,
                    input logic we, input logic ld, input logic hr);
    u_if.ID_VALID   = v;
    u_if.ID_RS1     = rs1;
    u_if.ID_RS2     = rs2;
    u_if.ID_USE_RS1 = u1;
    u_if.ID_USE_RS2 = u2;
    u_if.ID_RD      = rd;
    u_if.ID_RF_WE   = we;
    u_if.ID_IS_LOAD = ld;
    u_if.HALT_REQ   = hr;
  endtask

  task automatic nop();
    id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    nop();
    u_if.EX_REDIRECT = 1'b0;
    #1;
    chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst.fwd_a", 32'(u_if.FWD_A), 32'd0);
    chk("rst.fwd_b", 32'(u_if.FWD_B), 32'd0);
    chk("rst.halt",  32'(u_if.HALT), 32'd0);
    chk("rst.cnt",   32'(u_if.STALL_CNT), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // load-use: lw x5 then add x6,x5,x7
    id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);
    #1 chk_ctl("lw_issue", 1, 1, 0, 0);
    tick();
    id(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0);
    #1 chk_ctl("lu_stall", 0, 0, 0, 1);
    tick();
    #1 chk("lu_cnt", 32'(u_if.STALL_CNT), 32'd1);
    chk_ctl("lu_release", 1, 1, 0, 0);
    chk("lu_bubble_fwd_a", 32'(u_if.FWD_A), 32'd0);
    tick();
    nop();
    #1 chk("lu_fwd_a", 32'(u_if.FWD_A), 32'd2);
    chk("lu_fwd_b", 32'(u_if.FWD_B), 32'd0);
    chk("lu_cnt_hold", 32'(u_if.STALL_CNT), 32'd1);

    // lw x0 followed by a reader of x0: no hazard
    tick();
    id(1, 5'd2, 5'd0, 1, 0, 5'd0, 1, 1, 0);
    tick();
    id(1, 5'd0, 5'd0, 1, 0, 5'd10, 1, 0, 0);
    #1 chk_ctl("x0_nostall", 1, 1, 0, 0);
    tick();
    nop();
    #1 chk("x0_fwd_a", 32'(u_if.FWD_A), 32'd0);
    chk("x0_cnt", 32'(u_if.STALL_CNT), 32'd1);

    // x3 produced twice; reader sees MEM copy, then WB-only case
    tick();
    id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    tick();
    id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    tick();
    id(1, 5'd4, 5'd3, 1, 1, 5'd8, 1, 0, 0);
    tick();
    id(1, 5'd3, 5'd8, 1, 1, 5'd9, 1, 0, 0);
    #1 chk("mem_wins.fwd_b", 32'(u_if.FWD_B), 32'd1);
    chk("mem_wins.fwd_a", 32'(u_if.FWD_A), 32'd0);
    tick();
    id(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 1, 0);
    #1 chk("wb_only.fwd_a", 32'(u_if.FWD_A), 32'd2);
    chk("mem_x8.fwd_b", 32'(u_if.FWD_B), 32'd1);

    // redirect overrides a live load-use pair
    tick();
    id(1, 5'd9, 5'd0, 1, 0, 5'd11, 1, 0, 0);
    u_if.EX_REDIRECT = 1'b1;
    #1 chk_ctl("redir_lu", 1, 1, 1, 1);
    tick();
    u_if.EX_REDIRECT = 1'b0;
    nop();
    #1 chk("redir_cnt", 32'(u_if.STALL_CNT), 32'd1);
    chk_ctl("post_redir", 1, 1, 0, 0);

    // back-to-back self-dependent loads: stall on every other cycle
    tick();
    id(1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      #1 chk("sat_loop.pc_we", 32'(u_if.PC_WE), (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    nop();
    #1 chk("sat_main_cnt", 32'(u_if.STALL_CNT), 32'd11);
    chk("sat_narrow_cnt", 32'(s_if.STALL_CNT), 32'd7);

    // halt drain: issue at t, DRAIN t+1..t+3, HALT from t+4
    tick();
    id(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
    #1 chk_ctl("halt_issue", 1, 1, 0, 0);
    tick();
    nop();
    u_if.EX_REDIRECT = 1'b1;
    #1 chk_ctl("drain1", 0, 0, 1, 1);
    chk("drain1.halt", 32'(u_if.HALT), 32'd0);
    tick();
    u_if.EX_REDIRECT = 1'b0;
    #1 chk_ctl("drain2", 0, 0, 1, 1);
    chk("drain2.halt", 32'(u_if.HALT), 32'd0);
    tick();
    #1 chk_ctl("drain3", 0, 0, 1, 1);
    chk("drain3.halt", 32'(u_if.HALT), 32'd0);
    tick();
    #1 chk("halted.halt", 32'(u_if.HALT), 32'd1);
    chk("halted.pc_we", 32'(u_if.PC_WE), 32'd0);
    chk("halted.ifid_we", 32'(u_if.IFID_WE), 32'd0);
    chk("halted.bubble", 32'(u_if.IDEX_BUBBLE), 32'd1);
    tick();
    id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    #1 chk("sticky.halt", 32'(u_if.HALT), 32'd1);
    chk("sticky.pc_we", 32'(u_if.PC_WE), 32'd0);
    chk("sticky.cnt", 32'(u_if.STALL_CNT), 32'd11);

    // reset out of HALTED
    RST = 1'b1;
    #1 chk("rst2.halt", 32'(u_if.HALT), 32'd0);
    chk("rst2.cnt", 32'(u_if.STALL_CNT), 32'd0);
    chk("rst2.narrow_cnt", 32'(s_if.STALL_CNT), 32'd0);
    chk_ctl("rst2", 0, 0, 0, 1);
    tick();
    RST = 1'b0;
    id(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
    #1 chk_ctl("halt2_issue", 1, 1, 0, 0);
    tick();
    nop();
    #1 chk_ctl("drain_b", 0, 0, 1, 1);

    // asynchronous reset mid-DRAIN
    #2 RST = 1'b1;
    #1 chk("rst_mid.halt", 32'(u_if.HALT), 32'd0);
    chk_ctl("rst_mid", 0, 0, 0, 1);
    @(negedge CLK);
    RST = 1'b0;
    #1 chk_ctl("post_rst", 1, 1, 0, 0);
    chk("post_rst.cnt", 32'(u_if.STALL_CNT), 32'd0);
    repeat (5) tick();
    #1 chk("no_halt_after_rst", 32'(u_if.HALT), 32'd0);
    chk("run_after_rst.pc_we", 32'(u_if.PC_WE), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
